// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the digit-serial signed adder.
//   state_t    : FSM state encoding (IDLE, RUN, DONE)
//   cnt_width  : width of the digit counter for a given N/D, never below 1
//   RST_*      : reset values of the top-level registers
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned d);
        int unsigned w;
        w = $clog2(n / d);
        return (w < 1) ? 1 : w;
    endfunction

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_CARRY = 1'b0;
    localparam logic   RST_SIGN  = 1'b0;

endpackage

// File: rtl/rca_digit.sv
// Combinational D-bit ripple-carry adder slice.
// Ports:
//   x, y : D-bit addend digits
//   cin  : carry into bit 0
//   s    : D-bit sum digit
//   cout : carry out of bit D-1
module rca_digit #(
    parameter int unsigned D = 2
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    input  logic         cin,
    output logic [D-1:0] s,
    output logic         cout
);

    logic c;

    always_comb begin
        s = '0;
        c = cin;
        for (int i = 0; i < int'(D); i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_signed_adder.sv
// Digit-serial two's-complement adder: N-bit signed a and b in, exact (N+1)-bit
// signed sum out, D bits per clock, N/D cycles per operation.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   sub                  : (SERIAL_ADDER_SUB_EN builds only) compute a-b instead of a+b
//   in_valid / in_ready  : operand handshake, accepted only in IDLE
//   a, b                 : N-bit signed operands
//   out_valid / out_ready: result handshake, result held while out_ready=0
//   o                    : (N+1)-bit registered signed result
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub input.
module serial_signed_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned D = 2
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   o
);

    localparam int unsigned STEPS = N / D;
    localparam int unsigned CW    = cnt_width(N, D);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if ((N < 2) || (D < 1) || (D > N) || ((N % D) != 0)) begin : g_param_check
        $fatal(1, "serial_signed_adder: N must be >= 2 and a multiple of D (1 <= D <= N)");
    end

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N:0]      o_q, o_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // a[N-1] ^ b_eff[N-1], captured at acceptance because the shifters lose the MSBs
    logic            sign_q, sign_d;

    logic [N-1:0]    b_eff;
    logic            cin0;
    logic [D-1:0]    sum;
    logic            cout;
    logic [N-1:0]    res_shift;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b == a + ~b + 1
    assign b_eff = sub ? ~b : b;
    assign cin0  = sub;
`else
    assign b_eff = b;
    assign cin0  = 1'b0;
`endif

    rca_digit #(
        .D(D)
    ) u_rca (
        .x    (a_q[D-1:0]),
        .y    (b_q[D-1:0]),
        .cin  (carry_q),
        .s    (sum),
        .cout (cout)
    );

    // New sum digit enters at the MSB end; after N/D steps the low digit is at bit 0.
    if (D == N) begin : g_single_digit
        assign res_shift = sum;
    end else begin : g_multi_digit
        assign res_shift = {sum, o_q[N-1:D]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        o_d     = o_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin0;
                    cnt_d   = '0;
                    sign_d  = a[N-1] ^ b_eff[N-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d            = a_q >> D;
                b_d            = b_q >> D;
                carry_d        = cout;
                o_d[N-1:0]     = res_shift;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // cout here is the carry out of bit N-1
                    o_d[N]  = sign_q ^ cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            a_q     <= '0;
            b_q     <= '0;
            o_q     <= '0;
            carry_q <= RST_CARRY;
            cnt_q   <= '0;
            sign_q  <= RST_SIGN;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            o_q     <= o_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign o         = o_q;

endmodule

// File: tb/tb_serial_signed_adder.sv
// Self-checking bench for serial_signed_adder: N=8/D=2 main instance plus
// N=16/D=16 and N=16/D=1 instances sharing one stimulus bus.
module tb_serial_signed_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // N=8, D=2
    logic        iv8, ir8, ov8, or8, sub8;
    logic [7:0]  a8, b8;
    logic [8:0]  o8;
    // N=16, D=16 (w) and N=16, D=1 (s) share inputs
    logic        iv16, or16, sub16;
    logic [15:0] a16, b16;
    logic        ir16w, ov16w, ir16s, ov16s;
    logic [16:0] o16w, o16s;

    serial_signed_adder #(.N(8), .D(2)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub8),
`endif
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .o         (o8)
    );

    serial_signed_adder #(.N(16), .D(16)) u_dut16w (
        .clk       (clk),
        .rst       (rst),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub16),
`endif
        .in_valid  (iv16),
        .in_ready  (ir16w),
        .a         (a16),
        .b         (b16),
        .out_valid (ov16w),
        .out_ready (or16),
        .o         (o16w)
    );

    serial_signed_adder #(.N(16), .D(1)) u_dut16s (
        .clk       (clk),
        .rst       (rst),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub16),
`endif
        .in_valid  (iv16),
        .in_ready  (ir16s),
        .a         (a16),
        .b         (b16),
        .out_valid (ov16s),
        .out_ready (or16),
        .o         (o16s)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        int         exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the signed operand values.
    function automatic int model(input int x, input int y, input logic s);
        return s ? (x - y) : (x + y);
    endfunction

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n = 0;
        while (!ir8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready8", int'(ir8), 1);
        a8   = a;
        b8   = b;
        sub8 = s;
        iv8  = 1'b1;
        @(posedge clk); #1;
        iv8  = 1'b0;
    endtask

    task automatic wait8(input int exp);
        int n = 0;
        while (!ov8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency8", n, 4);
        check("sum8", int'($signed(o8)), exp);
    endtask

    task automatic finish8(input int hold, input int exp);
        or8 = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid8", int'(ov8), 1);
            check("hold_o8", int'($signed(o8)), exp);
            check("hold_ready8", int'(ir8), 0);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("release_valid8", int'(ov8), 0);
        check("release_ready8", int'(ir8), 1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int lw = -1;
        int ls = -1;
        int exp;
        exp = model(int'($signed(a)), int'($signed(b)), s);
        check("ready16", int'(ir16w & ir16s), 1);
        a16   = a;
        b16   = b;
        sub16 = s;
        iv16  = 1'b1;
        or16  = 1'b0;
        @(posedge clk); #1;
        iv16  = 1'b0;
        for (int n = 1; n <= 40 && (lw < 0 || ls < 0); n++) begin
            @(posedge clk); #1;
            if (ov16w && lw < 0) lw = n;
            if (ov16s && ls < 0) ls = n;
        end
        check("latency16_d16", lw, 1);
        check("latency16_d1", ls, 16);
        // the D=16 instance has sat in DONE for 15 cycles by now
        check("sum16_d16", int'($signed(o16w)), exp);
        check("sum16_d1", int'($signed(o16s)), exp);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check("release16", int'(ov16w | ov16s), 0);
    endtask

    initial begin
        int seen;
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;
        logic        rs;
        int          hold;

        iv8 = 0; or8 = 0; sub8 = 0; a8 = 0; b8 = 0;
        iv16 = 0; or16 = 0; sub16 = 0; a16 = 0; b16 = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready8", int'(ir8), 1);
        check("rst_out_valid8", int'(ov8), 0);
        check("rst_o8", int'(o8), 0);
        check("rst_o16", int'(o16w | o16s), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table, expected values derived by hand
        vecs.push_back('{8'h80, 8'h80, 1'b0, -256});
        vecs.push_back('{8'h7f, 8'h7f, 1'b0, 254});
        vecs.push_back('{8'hff, 8'hff, 1'b0, -2});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 0});
        vecs.push_back('{8'h7f, 8'h01, 1'b0, 128});
        vecs.push_back('{8'h80, 8'hff, 1'b0, -129});
        vecs.push_back('{8'd100, 8'd27, 1'b0, 127});
        vecs.push_back('{8'h05, 8'hf7, 1'b0, -4});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h80, 8'h7f, 1'b1, -255});
        vecs.push_back('{8'h00, 8'h80, 1'b1, 128});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 0});
        vecs.push_back('{8'h7f, 8'h80, 1'b1, 255});
`endif
        foreach (vecs[i]) begin
            start8(vecs[i].a, vecs[i].b, vecs[i].s);
            wait8(vecs[i].exp);
            finish8(0, vecs[i].exp);
        end

        // Backpressure: result frozen for 10 cycles
        start8(8'hff, 8'hff, 1'b0);
        wait8(-2);
        finish8(10, -2);

        // Reset during the second RUN cycle aborts the operation
        start8(8'd100, 8'd27, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid8", int'(ov8), 0);
        check("abort_o8", int'(o8), 0);
        check("abort_in_ready8", int'(ir8), 1);
        #1 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov8) seen++;
        end
        check("abort_no_result8", seen, 0);
        start8(8'h05, 8'hf7, 1'b0);
        wait8(-4);
        finish8(0, -4);

        // in_valid pulses during RUN and DONE are ignored
        start8(8'd10, 8'd20, 1'b0);
        a8  = 8'd99;
        b8  = 8'd99;
        iv8 = 1'b1;
        wait8(30);
        @(posedge clk); #1;
        check("ignore_valid8", int'(ov8), 1);
        check("ignore_o8", int'($signed(o8)), 30);
        iv8 = 1'b0;
        finish8(0, 30);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov8 || !ir8) seen++;
        end
        check("ignore_no_second8", seen, 0);

        // Width corners
        op16(16'h8000, 16'hffff, 1'b0);
        op16(16'h7fff, 16'h0001, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        op16(16'h8000, 16'h7fff, 1'b1);
        op16(16'h0000, 16'h8000, 1'b1);
`endif
        repeat (20) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            op16(wa, wb, rs);
        end

        // Randomized operations against the reference model
        repeat (1500) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs   = 1'($urandom);
`else
            rs   = 1'b0;
`endif
            hold = int'($urandom_range(0, 3));
            start8(ra, rb, rs);
            wait8(model(int'($signed(ra)), int'($signed(rb)), rs));
            finish8(hold, model(int'($signed(ra)), int'($signed(rb)), rs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
